mem_arbiter: RTL and testbench

- Parametrised successor to the present single-port memory controller.
- Arbitrates N_CH requester channels (icache fetch, LSB load, ROB store, and future ports such as a D-cache) onto the single byte-wide RAM/IO bus.
- Serialises 1/2/4-byte accesses into byte cycles and provides selectable fixed or round-robin arbitration.
- Supports per-channel flush masking, and stalls UART writes while io_buffer_full is high.

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter_rr.sv | 34 +++
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_defs: shared encodings and helpers for the memory arbiter.
package mem_defs;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] IO_SEL = 2'b11;
  localparam int IO_HI = 17;
  localparam int IO_LO = 16;
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  function automatic logic [2:0] size_to_bytes(input logic [1:0] s);
    return (s == SZ_W || s == 2'd3) ? 3'd4 : s == SZ_H ? 3'd2 : (s == SZ_B ? 3'd1 : 3'd4);
  endfunction
endpackage

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter: fixed-priority or round-robin grant with a next-start pointer.
module rr_arbiter #(
  parameter int N = 3,
  parameter int MODE = 1,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] ptr, cand;
  logic hit;
  always_comb begin
    idx = '0;
    hit = 1'b0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'(MODE == 1 ? (int'(ptr) + i) % N : i);
      if (!hit && req[cand]) begin
        idx = cand;
        hit = 1'b1;
      end
    end
    gnt = (en && hit) ? N'(1) << idx : '0;
  end
  // ptr holds where the next search starts, i.e. one past the last grant
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (en && hit) ptr <= IW'((int'(idx) + 1) % N);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates N_CH requesters onto a byte-wide RAM/IO bus.
module mem_arbiter
  import mem_defs::*;
#(
  parameter int N_CH = 3,
  parameter int ARB_MODE = 1,
  parameter logic [N_CH-1:0] FLUSH_MASK = 3'b011,
  parameter bit IO_HOLD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH-1:0]   we,
  input  logic [2*N_CH-1:0] size,
  input  logic [32*N_CH-1:0] addr,
  input  logic [32*N_CH-1:0] wdata,
  output logic [N_CH-1:0]   done,
  output logic [31:0]       rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [31:0]       mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);
  localparam int IW = N_CH > 1 ? $clog2(N_CH) : 1;
  state_t state, nxt;
  logic [N_CH-1:0] elig, gnt;
  logic [IW-1:0] gidx, ch;
  logic [31:0] g_addr, g_wdata, l_addr, l_wdata, rbuf, rnext;
  logic [1:0] g_size;
  logic g_we, l_io, l_fl, accept, hold, abort, issue;
  logic [2:0] k, c, cm1;
  assign elig = req & ~done & ~({N_CH{flush}} & ~we & FLUSH_MASK);
  rr_arbiter #(.N(N_CH), .MODE(ARB_MODE)) u_arb (
    .clk(clk),
    .rst(rst),
    .en(rdy && state == IDLE && done == '0),
    .req(elig),
    .gnt(gnt),
    .idx(gidx)
  );
  always_comb begin
    g_addr = addr[32*gidx +: 32];
    g_wdata = wdata[32*gidx +: 32];
    g_size = size[2*gidx +: 2];
    g_we = we[gidx];
    accept = |gnt;
    hold = state == WRITE && l_io && io_buffer_full;
    abort = state == READ && l_fl && flush;
    issue = (state == READ && c < k) || (state == WRITE && !hold);
    cm1 = c - 3'd1;
    // the byte on mem_din answers the address issued one cycle earlier
    rnext = rbuf | (32'(mem_din) << {cm1, 3'b000});
    mem_a = issue ? l_addr + 32'(c) : '0;
    mem_wr = rdy && state == WRITE && !hold;
    mem_dout = (state == WRITE && !hold) ? 8'(l_wdata >> {c, 3'b000}) : '0;
    nxt = state == IDLE ? (accept ? (g_we ? WRITE : READ) : IDLE) :
          state == READ ? ((abort || c == k) ? IDLE : READ) :
          ((!hold && c == k - 3'd1) ? IDLE : WRITE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done <= '0;
      rdata <= '0;
      ch <= '0;
      c <= '0;
      k <= '0;
      l_addr <= '0;
      l_wdata <= '0;
      l_io <= 1'b0;
      l_fl <= 1'b0;
      rbuf <= '0;
    end else if (rdy) begin
      state <= nxt;
      done <= '0;
      if (accept) begin
        ch <= gidx;
        c <= '0;
        k <= size_to_bytes(g_size);
        l_addr <= g_addr;
        l_wdata <= g_wdata;
        l_io <= IO_HOLD && g_we && g_addr[IO_HI:IO_LO] == IO_SEL;
        l_fl <= FLUSH_MASK[gidx];
        rbuf <= '0;
      end else if (state == READ) begin
        c <= c + 3'd1;
        if (c != 3'd0) rbuf <= rnext;
        if (c == k && !abort) begin
          done <= N_CH'(1) << ch;
          rdata <= rnext;
        end
      end else if (state == WRITE && !hold) begin
        c <= c + 3'd1;
        if (c == k - 3'd1) done <= N_CH'(1) << ch;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed timing checks plus a randomized run against a transaction-level model.
module tb_mem_arbiter;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst, rdy, flush, io_buffer_full;
  logic [N-1:0] req, we, done, done_f;
  logic [2*N-1:0] size;
  logic [32*N-1:0] addr, wdata;
  logic [31:0] rdata, rdata_f, mem_a, mem_a_f;
  logic [7:0] mem_din, mem_dout, mem_dout_f;
  logic mem_wr, mem_wr_f;
  logic [7:0] ram [0:1023];
  logic [7:0] ref_mem [0:1023];
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .req(req), .we(we), .size(size),
    .addr(addr), .wdata(wdata), .done(done), .rdata(rdata), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );
  mem_arbiter #(.ARB_MODE(0)) dut_f (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .req(req), .we(we), .size(size),
    .addr(addr), .wdata(wdata), .done(done_f), .rdata(rdata_f), .mem_din(mem_din),
    .mem_dout(mem_dout_f), .mem_a(mem_a_f), .mem_wr(mem_wr_f), .io_buffer_full(io_buffer_full)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RAM with one-cycle read latency, clocked only while rdy is high
  task automatic nx();
    logic [7:0] d;
    d = mem_din;
    if (rdy) begin
      d = ram[mem_a[9:0]];
      if (mem_wr) ram[mem_a[9:0]] = mem_dout;
    end
    @(posedge clk);
    mem_din <= d;
    #1;
  endtask

  task automatic setch(input int i, input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    we[i] = w;
    size[2*i +: 2] = s;
    addr[32*i +: 32] = a;
    wdata[32*i +: 32] = d;
  endtask

  initial begin
    logic [2:0] ord [4];
    logic [2:0] dseen, edone;
    int gap [N];
    int free_at, exp_done, exp_ch, ptr, k, diff;
    logic exp_we;
    logic [31:0] exp_rd, a, d;
    ord = '{3'b001, 3'b010, 3'b100, 3'b001};
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    req = '0; we = '0; size = '0; addr = '0; wdata = '0;
    mem_din <= 8'h00;
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    nx(); nx();
    rst = 1'b0;
    #1;
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_dout", mem_dout, 0);
    chk("rst_wr", mem_wr, 0);
    // word read, ch1
    ram[256] = 8'h11; ram[257] = 8'h22; ram[258] = 8'h33; ram[259] = 8'h44;
    setch(1, 1'b0, 2'd2, 32'h100, 0);
    req = 3'b010;
    for (int j = 0; j < 4; j++) begin
      nx();
      chk("t1_addr", mem_a, 32'h100 + j);
    end
    nx(); chk("t1_early", done, 0);
    nx(); chk("t1_done", done, 3'b010); chk("t1_rdata", rdata, 32'h44332211);
    nx(); req = '0;
    // half write, ch2
    setch(2, 1'b1, 2'd1, 32'h20, 32'hABCD);
    req = 3'b100;
    nx(); chk("t2_wr0", mem_wr, 1); chk("t2_a0", mem_a, 32'h20); chk("t2_d0", mem_dout, 8'hCD);
    nx(); chk("t2_wr1", mem_wr, 1); chk("t2_a1", mem_a, 32'h21); chk("t2_d1", mem_dout, 8'hAB);
    nx(); chk("t2_done", done, 3'b100); chk("t2_wr_off", mem_wr, 0);
    nx(); req = '0;
    chk("t2_ram", {ram[33], ram[32]}, 32'hABCD);
    // all three channels hold byte reads
    ram[16] = 8'hA0; ram[17] = 8'hA1; ram[18] = 8'hA2;
    for (int i = 0; i < N; i++) setch(i, 1'b0, 2'd0, 32'h10 + i, 0);
    req = 3'b111;
    for (int t = 0; t < 4; t++) begin
      for (int n = 0; n < 10 && done == '0; n++) nx();
      chk("t3_seen", done != '0, 1);
      chk("t3_rr_order", done, ord[t]);
      chk("t3_rr_rdata", rdata, 32'hA0 + (t % 3));
      chk("t3_fixed_order", done_f, 3'b001);
      nx();
    end
    req = '0;
    // flush aborts a flushable read
    setch(0, 1'b0, 2'd2, 32'h40, 0);
    req = 3'b001;
    nx(); nx(); flush = 1'b1;
    nx(); flush = 1'b0; req = '0;
    chk("t4_idle_a", mem_a, 0); chk("t4_nodone", done, 0);
    for (int n = 0; n < 3; n++) begin
      nx();
      chk("t4_idle_a", mem_a, 0);
      chk("t4_nodone", done, 0);
    end
    flush = 1'b1; req = 3'b001;
    nx(); chk("t4_blocked", mem_a, 0); flush = 1'b0;
    nx(); chk("t4_accept", mem_a, 32'h40);
    for (int n = 0; n < 10 && done == '0; n++) nx();
    chk("t4_read_done", done, 3'b001);
    nx(); req = '0;
    // flush never stops a write
    setch(2, 1'b1, 2'd2, 32'h50, 32'hDEADBEEF);
    req = 3'b100;
    for (int j = 0; j < 4; j++) begin
      nx(); flush = 1'b1;
      chk("t4_wr", mem_wr, 1); chk("t4_wa", mem_a, 32'h50 + j);
      chk("t4_wd", mem_dout, 8'(32'hDEADBEEF >> (8 * j)));
    end
    nx(); flush = 1'b0;
    chk("t4_wdone", done, 3'b100);
    nx(); req = '0;
    chk("t4_ram", {ram[83], ram[82], ram[81], ram[80]}, 32'hDEADBEEF);
    // IO write held while the UART buffer is full
    setch(1, 1'b1, 2'd0, 32'h30000, 32'h5A);
    io_buffer_full = 1'b1; req = 3'b010;
    for (int n = 0; n < 3; n++) begin
      nx(); chk("t5_hold_wr", mem_wr, 0); chk("t5_hold_a", mem_a, 0);
    end
    nx(); io_buffer_full = 1'b0; #1;
    chk("t5_wr", mem_wr, 1); chk("t5_a", mem_a, 32'h30000); chk("t5_d", mem_dout, 8'h5A);
    nx(); chk("t5_done", done, 3'b010);
    nx(); req = '0;
    // rdy stall in the middle of a word read
    setch(0, 1'b0, 2'd2, 32'h100, 0);
    req = 3'b001;
    nx(); chk("t6_a0", mem_a, 32'h100);
    nx(); rdy = 1'b0; #1; chk("t6_stall_a", mem_a, 32'h101); chk("t6_stall_wr", mem_wr, 0);
    nx(); chk("t6_stall_a", mem_a, 32'h101); chk("t6_stall_wr", mem_wr, 0);
    nx(); rdy = 1'b1; #1; chk("t6_resume_a", mem_a, 32'h101);
    nx(); chk("t6_a2", mem_a, 32'h102);
    nx(); chk("t6_a3", mem_a, 32'h103);
    nx(); chk("t6_early", done, 0);
    nx(); chk("t6_done", done, 3'b001); chk("t6_rdata", rdata, 32'h44332211);
    nx(); req = '0;
    // reset in the middle of a write
    setch(2, 1'b1, 2'd2, 32'h60, 32'h01020304);
    req = 3'b100;
    nx(); chk("t6_rst_pre", mem_wr, 1);
    nx(); rst = 1'b1; req = '0;
    nx(); rst = 1'b0; #1;
    chk("t6_rst_wr", mem_wr, 0); chk("t6_rst_a", mem_a, 0); chk("t6_rst_d", mem_dout, 0);
    chk("t6_rst_done", done, 0); chk("t6_rst_rdata", rdata, 0);
    for (int n = 0; n < 3; n++) begin
      nx(); chk("t6_rst_nodone", done, 0);
    end
    // randomized traffic against a transaction-level model
    for (int i = 0; i < 1024; i++) ref_mem[i] = ram[i];
    for (int i = 0; i < N; i++) gap[i] = $urandom_range(0, 3);
    dseen = '0; free_at = 0; exp_done = -1; exp_ch = 0; ptr = 0; exp_we = 1'b0; exp_rd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (n > 0) nx();
      for (int i = 0; i < N; i++) begin
        if (dseen[i]) begin
          req[i] = 1'b0; dseen[i] = 1'b0; gap[i] = $urandom_range(0, 3);
        end else if (!req[i] && n < 2950) begin
          if (gap[i] > 0) gap[i]--;
          else if ($urandom_range(0, 1) == 0) begin
            setch(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, 1000), $urandom);
            req[i] = 1'b1;
          end
        end
      end
      if (n >= free_at && req != '0) begin
        for (int o = 0; o < N; o++)
          if (req[(ptr + o) % N]) begin
            exp_ch = (ptr + o) % N;
            break;
          end
        ptr = (exp_ch + 1) % N;
        exp_we = we[exp_ch];
        k = size[2*exp_ch +: 2] == 2'd0 ? 1 : size[2*exp_ch +: 2] == 2'd1 ? 2 : 4;
        a = addr[32*exp_ch +: 32];
        d = wdata[32*exp_ch +: 32];
        exp_rd = '0;
        for (int j = 0; j < k; j++) begin
          if (exp_we) ref_mem[(a + j) % 1024] = d[8*j +: 8];
          else exp_rd[8*j +: 8] = ref_mem[(a + j) % 1024];
        end
        exp_done = n + k + (exp_we ? 1 : 2);
        free_at = exp_done + 1;
      end
      #1;
      edone = n == exp_done ? 3'(1 << exp_ch) : 3'b000;
      chk("rnd_done", done, edone);
      if (n == exp_done && !exp_we) chk("rnd_rdata", rdata, exp_rd);
      dseen = dseen | done;
    end
    diff = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) diff++;
    chk("rnd_mem_image", diff, 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
